// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares one single-port data-memory syncram between two requesters:
// requester 0 (processor) and requester 1 (loader/debug). Grants are
// combinational and round-robin. The accepted request is registered onto
// the syncram port. Read data comes back to the owning requester exactly
// two cycles after the grant.
//
// Ports
//   clock                    sole clock, rising edge
//   reset                    synchronous, active-high
//   r0_req / r1_req          access request
//   r0_addr / r1_addr        12-bit word address
//   r0_wdata / r1_wdata      32-bit write data
//   r0_wren / r1_wren        1 = write, 0 = read
//   r0_gnt / r1_gnt          request accepted this cycle (combinational)
//   r0_rvalid / r1_rvalid    read data valid for that requester
//   r0_rdata / r1_rdata      read data, zero when rvalid is low
//   address_dmem, data, wren registered drive to the syncram
//   q_dmem                   syncram read data, one cycle after the address
module dmem_arbiter (
  input  logic        clock,
  input  logic        reset,
  input  logic        r0_req,
  input  logic        r1_req,
  input  logic [11:0] r0_addr,
  input  logic [11:0] r1_addr,
  input  logic [31:0] r0_wdata,
  input  logic [31:0] r1_wdata,
  input  logic        r0_wren,
  input  logic        r1_wren,
  output logic        r0_gnt,
  output logic        r1_gnt,
  output logic        r0_rvalid,
  output logic        r1_rvalid,
  output logic [31:0] r0_rdata,
  output logic [31:0] r1_rdata,
  output logic [11:0] address_dmem,
  output logic [31:0] data,
  output logic        wren,
  input  logic [31:0] q_dmem
);

  // Last-grant pointer. The requester that did not win last time wins
  // the next contention.
  typedef enum logic {
    LAST_R0 = 1'b0,
    LAST_R1 = 1'b1
  } last_t;

  last_t       last_q;
  last_t       last_d;

  logic        accept;
  logic        sel_id;
  logic [11:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_wren;

  // Response pipeline: stage 1 is the cycle the syncram sees the address,
  // stage 2 is the cycle q_dmem carries the data.
  logic        p1_valid;
  logic        p1_id;
  logic        p1_is_read;
  logic        p2_valid;
  logic        p2_id;
  logic        p2_is_read;

  // Grant logic and next pointer. No grant during reset, so a request seen
  // in a reset cycle is never accepted.
  always_comb begin
    r0_gnt = 1'b0;
    r1_gnt = 1'b0;
    last_d = last_q;
    if (!reset) begin
      if (r0_req && r1_req) begin
        if (last_q == LAST_R1) begin
          r0_gnt = 1'b1;
        end else begin
          r1_gnt = 1'b1;
        end
      end else if (r0_req) begin
        r0_gnt = 1'b1;
      end else if (r1_req) begin
        r1_gnt = 1'b1;
      end
      if (r0_gnt) begin
        last_d = LAST_R0;
      end else if (r1_gnt) begin
        last_d = LAST_R1;
      end
    end
  end

  assign accept    = r0_gnt | r1_gnt;
  assign sel_id    = r1_gnt;
  assign sel_addr  = r1_gnt ? r1_addr  : r0_addr;
  assign sel_wdata = r1_gnt ? r1_wdata : r0_wdata;
  assign sel_wren  = r1_gnt ? r1_wren  : r0_wren;

  // Pointer, memory-port and response pipeline registers. Without an
  // acceptance the port only drops wren; address and data keep their
  // previous values.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_q       <= LAST_R1;
      address_dmem <= 12'd0;
      data         <= 32'd0;
      wren         <= 1'b0;
      p1_valid     <= 1'b0;
      p1_id        <= 1'b0;
      p1_is_read   <= 1'b0;
      p2_valid     <= 1'b0;
      p2_id        <= 1'b0;
      p2_is_read   <= 1'b0;
    end else begin
      last_q <= last_d;
      if (accept) begin
        address_dmem <= sel_addr;
        data         <= sel_wdata;
        wren         <= sel_wren;
      end else begin
        wren <= 1'b0;
      end
      p1_valid   <= accept;
      p1_id      <= sel_id;
      p1_is_read <= ~sel_wren;
      p2_valid   <= p1_valid;
      p2_id      <= p1_id;
      p2_is_read <= p1_is_read;
    end
  end

  assign r0_rvalid = p2_valid && p2_is_read && (p2_id == 1'b0);
  assign r1_rvalid = p2_valid && p2_is_read && (p2_id == 1'b1);
  assign r0_rdata  = r0_rvalid ? q_dmem : 32'd0;
  assign r1_rdata  = r1_rvalid ? q_dmem : 32'd0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// Directed bench for dmem_arbiter. A behavioural syncram registers the
// address and returns data one cycle later. Unwritten words return a
// fixed per-address pattern. Inputs change 1 time unit after the rising
// edge. Outputs are checked on the falling edge.
module tb_dmem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        r0_req, r1_req;
  logic [11:0] r0_addr, r1_addr;
  logic [31:0] r0_wdata, r1_wdata;
  logic        r0_wren, r1_wren;
  logic        r0_gnt, r1_gnt;
  logic        r0_rvalid, r1_rvalid;
  logic [31:0] r0_rdata, r1_rdata;
  logic [11:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_dmem;

  int assert_count = 0;
  int fail_count   = 0;

  logic [31:0] mem [0:4095];
  logic        written [0:4095] = '{default: 1'b0};

  always #5 clock = ~clock;

  dmem_arbiter dut (
    .clock        (clock),
    .reset        (reset),
    .r0_req       (r0_req),
    .r1_req       (r1_req),
    .r0_addr      (r0_addr),
    .r1_addr      (r1_addr),
    .r0_wdata     (r0_wdata),
    .r1_wdata     (r1_wdata),
    .r0_wren      (r0_wren),
    .r1_wren      (r1_wren),
    .r0_gnt       (r0_gnt),
    .r1_gnt       (r1_gnt),
    .r0_rvalid    (r0_rvalid),
    .r1_rvalid    (r1_rvalid),
    .r0_rdata     (r0_rdata),
    .r1_rdata     (r1_rdata),
    .address_dmem (address_dmem),
    .data         (data),
    .wren         (wren),
    .q_dmem       (q_dmem)
  );

  // Contents of words that have not been written yet
  function automatic logic [31:0] default_word(input logic [11:0] a);
    case (a)
      12'h001: return 32'h11111111;
      12'h002: return 32'h22222222;
      12'h003: return 32'h33333333;
      12'h005: return 32'hDEADBEEF;
      default: return {20'hA5A5A, a};
    endcase
  endfunction

  // Syncram model: address registered, data available the next cycle
  always @(posedge clock) begin
    if (wren) begin
      mem[address_dmem]     <= data;
      written[address_dmem] <= 1'b1;
    end
    q_dmem <= written[address_dmem] ? mem[address_dmem] : default_word(address_dmem);
  end

  task automatic applyStimulus(input logic rst,
                               input logic q0, input logic [11:0] a0,
                               input logic [31:0] d0, input logic w0,
                               input logic q1, input logic [11:0] a1,
                               input logic [31:0] d1, input logic w1);
    reset    = rst;
    r0_req   = q0;
    r0_addr  = a0;
    r0_wdata = d0;
    r0_wren  = w0;
    r1_req   = q1;
    r1_addr  = a1;
    r1_wdata = d1;
    r1_wren  = w1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assert_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle;
    @(posedge clock);
    #1;
  endtask

  task automatic idle;
    applyStimulus(1'b0, 1'b0, 12'h000, 32'd0, 1'b0, 1'b0, 12'h000, 32'd0, 1'b0);
  endtask

  initial begin
    logic [31:0] pipe_data [0:2];
    pipe_data[0] = 32'h11111111;
    pipe_data[1] = 32'h22222222;
    pipe_data[2] = 32'h33333333;

    // Reset with both requesting: neither may be granted
    applyStimulus(1'b1, 1'b1, 12'h005, 32'd0, 1'b0, 1'b1, 12'h006, 32'd0, 1'b0);
    @(negedge clock);
    checkOutput("rst_r0_gnt", r0_gnt, 32'd0);
    checkOutput("rst_r1_gnt", r1_gnt, 32'd0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 12'h000, 32'd0, 1'b0, 1'b0, 12'h000, 32'd0, 1'b0);
    nextCycle();

    // Cycle 1 after reset: cleared port, no responses
    idle();
    @(negedge clock);
    checkOutput("rst_wren", wren, 32'd0);
    checkOutput("rst_addr", address_dmem, 32'd0);
    checkOutput("rst_data", data, 32'd0);
    checkOutput("rst_r0_rvalid", r0_rvalid, 32'd0);
    checkOutput("rst_r1_rvalid", r1_rvalid, 32'd0);
    nextCycle();
    @(negedge clock);
    checkOutput("rst2_r0_rvalid", r0_rvalid, 32'd0);
    checkOutput("rst2_r1_rvalid", r1_rvalid, 32'd0);
    nextCycle();

    // Single read of 0x005 in cycle 3
    applyStimulus(1'b0, 1'b1, 12'h005, 32'd0, 1'b0, 1'b0, 12'h000, 32'd0, 1'b0);
    @(negedge clock);
    checkOutput("rd_r0_gnt", r0_gnt, 32'd1);
    checkOutput("rd_r1_gnt", r1_gnt, 32'd0);
    nextCycle();
    idle();
    @(negedge clock);
    checkOutput("rd_addr", address_dmem, 32'h005);
    checkOutput("rd_wren", wren, 32'd0);
    checkOutput("rd_c4_r0_rvalid", r0_rvalid, 32'd0);
    checkOutput("rd_c4_r1_rvalid", r1_rvalid, 32'd0);
    nextCycle();
    @(negedge clock);
    checkOutput("rd_r0_rvalid", r0_rvalid, 32'd1);
    checkOutput("rd_r0_rdata", r0_rdata, 32'hDEADBEEF);
    checkOutput("rd_c5_r1_rvalid", r1_rvalid, 32'd0);
    nextCycle();
    @(negedge clock);
    checkOutput("rd_c6_r0_rvalid", r0_rvalid, 32'd0);
    checkOutput("rd_c6_r0_rdata", r0_rdata, 32'd0);
    nextCycle();

    // Contention straight after reset: r0, r1, r0, r1
    applyStimulus(1'b1, 1'b0, 12'h000, 32'd0, 1'b0, 1'b0, 12'h000, 32'd0, 1'b0);
    nextCycle();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 12'h010, 32'd0, 1'b0, 1'b1, 12'h020, 32'd0, 1'b0);
      @(negedge clock);
      checkOutput($sformatf("cont%0d_r0_gnt", i), r0_gnt, (i % 2 == 0) ? 32'd1 : 32'd0);
      checkOutput($sformatf("cont%0d_r1_gnt", i), r1_gnt, (i % 2 == 1) ? 32'd1 : 32'd0);
      if (i == 2) begin
        checkOutput("cont2_r0_rdata", r0_rdata, 32'hA5A5A010);
        checkOutput("cont2_r1_rvalid", r1_rvalid, 32'd0);
      end
      if (i == 3) begin
        checkOutput("cont3_r1_rdata", r1_rdata, 32'hA5A5A020);
        checkOutput("cont3_r0_rvalid", r0_rvalid, 32'd0);
      end
      nextCycle();
    end
    idle();
    @(negedge clock);
    checkOutput("drain1_r0_rvalid", r0_rvalid, 32'd1);
    checkOutput("drain1_r0_rdata", r0_rdata, 32'hA5A5A010);
    nextCycle();
    @(negedge clock);
    checkOutput("drain2_r1_rvalid", r1_rvalid, 32'd1);
    checkOutput("drain2_r1_rdata", r1_rdata, 32'hA5A5A020);
    nextCycle();
    nextCycle();

    // r1 writes 0xFFF then reads it back in the next slot
    applyStimulus(1'b0, 1'b0, 12'h000, 32'd0, 1'b0, 1'b1, 12'hFFF, 32'h12345678, 1'b1);
    @(negedge clock);
    checkOutput("wr_r1_gnt", r1_gnt, 32'd1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 12'h000, 32'd0, 1'b0, 1'b1, 12'hFFF, 32'd0, 1'b0);
    @(negedge clock);
    checkOutput("wrrd_r1_gnt", r1_gnt, 32'd1);
    checkOutput("wr_wren", wren, 32'd1);
    checkOutput("wr_addr", address_dmem, 32'hFFF);
    checkOutput("wr_data", data, 32'h12345678);
    checkOutput("wr_r1_rvalid", r1_rvalid, 32'd0);
    nextCycle();
    idle();
    @(negedge clock);
    checkOutput("wrrd_wren", wren, 32'd0);
    checkOutput("wrrd_addr", address_dmem, 32'hFFF);
    checkOutput("wr_no_rvalid", r1_rvalid, 32'd0);
    nextCycle();
    @(negedge clock);
    checkOutput("wrrd_r1_rvalid", r1_rvalid, 32'd1);
    checkOutput("wrrd_r1_rdata", r1_rdata, 32'h12345678);
    checkOutput("wrrd_r0_rvalid", r0_rvalid, 32'd0);
    nextCycle();
    @(negedge clock);
    checkOutput("wrrd_end_r1_rvalid", r1_rvalid, 32'd0);
    nextCycle();

    // Back-to-back reads by r0 of 0x001, 0x002, 0x003
    for (int i = 0; i < 6; i++) begin
      if (i < 3) begin
        applyStimulus(1'b0, 1'b1, 12'(i + 1), 32'd0, 1'b0, 1'b0, 12'h000, 32'd0, 1'b0);
      end else begin
        idle();
      end
      @(negedge clock);
      if (i < 3) begin
        checkOutput($sformatf("pipe%0d_r0_gnt", i), r0_gnt, 32'd1);
      end
      if (i >= 2 && i <= 4) begin
        checkOutput($sformatf("pipe%0d_r0_rvalid", i), r0_rvalid, 32'd1);
        checkOutput($sformatf("pipe%0d_r0_rdata", i), r0_rdata, pipe_data[i - 2]);
      end else begin
        checkOutput($sformatf("pipe%0d_r0_rvalid", i), r0_rvalid, 32'd0);
      end
      nextCycle();
    end

    // Reset arrives the cycle after a read is granted
    applyStimulus(1'b0, 1'b1, 12'h005, 32'd0, 1'b0, 1'b0, 12'h000, 32'd0, 1'b0);
    @(negedge clock);
    checkOutput("mid_r0_gnt", r0_gnt, 32'd1);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 12'h006, 32'd0, 1'b0, 1'b1, 12'h0AA, 32'h55AA55AA, 1'b1);
    @(negedge clock);
    checkOutput("mid_rst_r0_gnt", r0_gnt, 32'd0);
    checkOutput("mid_rst_r1_gnt", r1_gnt, 32'd0);
    checkOutput("mid_rst_addr", address_dmem, 32'h005);
    nextCycle();
    idle();
    @(negedge clock);
    checkOutput("mid_r0_rvalid", r0_rvalid, 32'd0);
    checkOutput("mid_wren", wren, 32'd0);
    checkOutput("mid_addr", address_dmem, 32'd0);
    checkOutput("mid_data", data, 32'd0);
    nextCycle();
    @(negedge clock);
    checkOutput("mid2_r0_rvalid", r0_rvalid, 32'd0);
    checkOutput("mid2_r1_rvalid", r1_rvalid, 32'd0);
    nextCycle();

    // One r1 write followed by three idle cycles
    applyStimulus(1'b0, 1'b0, 12'h000, 32'd0, 1'b0, 1'b1, 12'h0AB, 32'hCAFEF00D, 1'b1);
    @(negedge clock);
    checkOutput("hold_r1_gnt", r1_gnt, 32'd1);
    nextCycle();
    idle();
    @(negedge clock);
    checkOutput("hold_wr_wren", wren, 32'd1);
    checkOutput("hold_wr_addr", address_dmem, 32'h0AB);
    checkOutput("hold_wr_data", data, 32'hCAFEF00D);
    nextCycle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      checkOutput($sformatf("hold%0d_wren", k), wren, 32'd0);
      checkOutput($sformatf("hold%0d_addr", k), address_dmem, 32'h0AB);
      checkOutput($sformatf("hold%0d_data", k), data, 32'hCAFEF00D);
      checkOutput($sformatf("hold%0d_r1_rvalid", k), r1_rvalid, 32'd0);
      nextCycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have exactly one clock domain, and every port SHALL be as listed in REQ-002 to REQ-012.
REQ-002 clock  input  1  sole clock; every register updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high; it is sampled on the rising edge of clock.
REQ-004 r0_req, r1_req  input  1 each  access request from requester 0 (processor) and requester 1 (loader/debug).
REQ-005 r0_addr, r1_addr  input  12 each  word address.
REQ-006 r0_wdata, r1_wdata  input  32 each  write data.
REQ-007 r0_wren, r1_wren  input  1 each  1 = write, 0 = read.
REQ-008 r0_gnt, r1_gnt  output  1 each  combinational acceptance of the request in the current cycle.
REQ-009 r0_rvalid, r1_rvalid  output  1 each  read data valid for that requester.
REQ-010 r0_rdata, r1_rdata  output  32 each  read data.
REQ-011 address_dmem (12), data (32), wren (1)  output  registered drive to the dmem syncram.
REQ-012 q_dmem  input  32  syncram read data, valid one cycle after the address is presented.

Function
REQ-013 A request SHALL be accepted in cycle N only when its req is high and its gnt is high; the requester holds addr, wdata and wren stable until it is accepted.
REQ-014 The arbiter SHALL grant at most one request per cycle; a request is granted in every cycle in which any req is high.
REQ-015 The arbiter SHALL use round-robin arbitration with a 1-bit last-grant pointer, last.
- Both requesting: the requester with index != last is granted.
- Single requester: that requester is granted regardless of last.
- last updates to the granted index at the end of every granted cycle and holds otherwise.
REQ-016 The memory port SHALL drive the request accepted in cycle N during cycle N+1: address_dmem = addr, data = wdata, wren = accepted wren.
REQ-017 In a cycle following one with no acceptance, wren SHALL be 0, and address_dmem and data SHALL hold their previous values.
REQ-018 For a read accepted in cycle N, rX_rvalid SHALL be 1 in cycle N+2 only, and rX_rdata SHALL equal q_dmem in that cycle; read latency is therefore fixed at 2 cycles.
REQ-019 Response routing SHALL use a 2-stage pipeline of {valid, id, is_read} that advances every cycle, so back-to-back accepts in consecutive cycles are supported with no bubble.
REQ-020 Writes SHALL produce no rvalid; the gnt is the only completion indication for a write.
REQ-021 rX_rdata SHALL be 0 whenever rX_rvalid is 0, and the rvalid of the non-addressed requester SHALL be 0.
REQ-022 A read that follows a write to the same address in the next accepted slot SHALL return the written data, using the syncram's old-data-free sequential ordering; no bypass logic SHALL be added.
REQ-023 Addresses SHALL pass through unmodified with no wrap or offset; the 12-bit address covers 4096 words.

Reset
REQ-024 While reset is high at a clock edge, the block SHALL clear: last = 1 (so requester 0 wins the first contention), address_dmem = 0, data = 0, wren = 0, and all pipeline valid bits = 0.
REQ-025 After reset, rX_rvalid SHALL be 0 for at least two cycles.
REQ-026 During any cycle in which reset is high, rX_gnt SHALL be 0, and no request presented in that cycle SHALL be accepted.
REQ-027 Reset mid-operation SHALL discard every in-flight read, so that no rvalid appears for a read accepted before the reset.

Verification
REQ-028 Directed scenario, single read: after reset, r0 reads addr 0x005 holding 0xDEADBEEF in cycle 3 -> r0_gnt = 1 in cycle 3; address_dmem = 0x005 with wren = 0 in cycle 4; r0_rvalid = 1 with r0_rdata = 0xDEADBEEF in cycle 5; r1_rvalid = 0 throughout.
REQ-029 Directed scenario, contention: r0 and r1 both request continuously for 4 cycles right after reset -> grants are r0, r1, r0, r1, with exactly one gnt per cycle.
REQ-030 Directed scenario, write then read: r1 writes 0x12345678 to 0xFFF, then r1 reads 0xFFF in the next cycle -> wren = 1 with address_dmem = 0xFFF for one cycle; r1_rvalid = 1 with r1_rdata = 0x12345678 two cycles after the read grant; no rvalid for the write.
REQ-031 Directed scenario, pipelined reads: r0 reads 0x001, 0x002, 0x003 in consecutive cycles -> three consecutive r0_rvalid cycles carrying the data in request order.
REQ-032 Directed scenario, reset mid-read: r0 read granted in cycle N, reset high in cycle N+1 -> no r0_rvalid in cycle N+2, and wren = 0 with address_dmem = 0 after reset.
REQ-033 Directed scenario, idle hold: one r1 write, then no requests for 3 cycles -> wren = 0 in the idle cycles, and address_dmem and data hold the last written values.
